// File: rtl/alu_pipe.sv
// alu_pipe: single-stage registered ALU with valid/ready handshake on both sides.
// Optional iterative shift-add multiplier (opcode 1001) is built only when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  logic             load_ok;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_ovf;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  // The output register may be (re)loaded when it is empty or being drained this edge.
  assign load_ok  = !out_valid || out_ready;
  assign in_ready = !busy && load_ok;
  assign accept   = in_valid && in_ready;

  assign shamt    = b[SHW-1:0];
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic               mul_req;
  logic               mul_last;
  logic               mul_step;

  assign is_mul   = (opcode == OP_MUL);
  assign mul_req  = accept && is_mul;
  assign mul_last = (state == S_MUL) && (cnt == SHW'(WIDTH - 1));
  // The final iteration holds until the output register can take the product.
  assign mul_done = mul_last && load_ok;
  assign mul_step = (state == S_MUL) && (!mul_last || load_ok);
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_lo   = acc_nxt[WIDTH-1:0];
  assign mul_ovf  = |acc_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mul_req) state_nxt = S_MUL;
      S_MUL:   if (mul_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_MUL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (mul_req) begin
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (mul_step) begin
      cnt    <= cnt + 1'b1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_lo   = '0;
  assign mul_ovf  = 1'b0;
  assign busy     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      result        <= '0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      zero_flag     <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid     <= 1'b1;
      result        <= alu_res;
      carry_flag    <= alu_c;
      overflow_flag <= alu_v;
      zero_flag     <= (alu_res == '0);
    end else if (mul_done) begin
      out_valid     <= 1'b1;
      result        <= mul_lo;
      carry_flag    <= 1'b0;
      overflow_flag <= mul_ovf;
      zero_flag     <= (mul_lo == '0);
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized streams scored
// against an arithmetic reference model, on a 64-bit and an 8-bit instance.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        iv64, ir64, ov64, or64, c64, v64, z64, busy64;
  logic [63:0] a64, b64, r64;
  logic [3:0]  op64;
  logic        iv8, ir8, ov8, or8, c8, v8, z8, busy8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  op8;

  alu_pipe #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .opcode(op64),
    .out_valid(ov64), .out_ready(or64), .result(r64), .carry_flag(c64), .overflow_flag(v64),
    .zero_flag(z64), .busy(busy64)
  );

  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .opcode(op8),
    .out_valid(ov8), .out_ready(or8), .result(r8), .carry_flag(c8), .overflow_flag(v8),
    .zero_flag(z8), .busy(busy8)
  );

  // Reference: operands treated as w-bit unsigned and signed integers in wide arithmetic.
  function automatic void ref_op(input int w, input logic [3:0] op, input logic [63:0] x,
                                 input logic [63:0] y, output logic [63:0] r, output logic c,
                                 output logic v, output logic z);
    logic [129:0] mask, ux, uy, full;
    logic signed [129:0] sx, sy, s, lo, hi;
    int sh;
    mask = (130'd1 << w) - 130'd1;
    ux = {66'd0, x} & mask;
    uy = {66'd0, y} & mask;
    sx = $signed(ux);
    if (ux[w-1]) sx = sx - $signed(130'd1 << w);
    sy = $signed(uy);
    if (uy[w-1]) sy = sy - $signed(130'd1 << w);
    hi = $signed((130'd1 << (w - 1)) - 130'd1);
    lo = -$signed(130'd1 << (w - 1));
    sh = int'(uy[5:0]) % w;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      4'd0:  begin full = ux + uy; s = sx + sy; c = full[w]; v = (s < lo) || (s > hi); end
      4'd8:  begin full = ux + ((~uy) & mask) + 130'd1; s = sx - sy; c = full[w]; v = (s < lo) || (s > hi); end
      4'd1:  full = ux << sh;
      4'd2:  full = (sx < sy) ? 130'd1 : 130'd0;
      4'd3:  full = (ux < uy) ? 130'd1 : 130'd0;
      4'd4:  full = ux ^ uy;
      4'd5:  full = ux >> sh;
      4'd6:  full = ux | uy;
      4'd7:  full = ux & uy;
      4'd13: full = $unsigned(sx >>> sh);
      4'd9:  begin
        full = '0;
        if (MUL_EN) begin full = ux * uy; v = ((full >> w) != 130'd0); end
      end
      default: full = '0;
    endcase
    r = 64'(full & mask);
    z = (r == 64'd0);
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return {64{1'b1}};
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    iv64 = 0; a64 = '0; b64 = '0; op64 = '0; or64 = 1'b1;
    iv8 = 0; a8 = '0; b8 = '0; op8 = '0; or8 = 1'b1;
    #2;
    checks++; if ({ov64, r64, c64, v64, z64, busy64} !== '0) begin errors++; $display("FAIL reset64 got ov=%b r=%h cvz=%b%b%b busy=%b exp all 0", ov64, r64, c64, v64, z64, busy64); end
    checks++; if ({ov8, r8, c8, v8, z8, busy8} !== '0) begin errors++; $display("FAIL reset8 got ov=%b r=%h cvz=%b%b%b busy=%b exp all 0", ov8, r8, c8, v8, z8, busy8); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov64 !== 1'b0 || ir64 !== 1'b1) begin errors++; $display("FAIL reset_hold got ov=%b ir=%b exp ov=0 ir=1", ov64, ir64); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_sub_corners();
    a64 = {64{1'b1}}; b64 = 64'd1; op64 = 4'b0000; iv64 = 1'b1; or64 = 1'b1;
    #1;
    checks++; if (ir64 !== 1'b1) begin errors++; $display("FAIL first_edge_ready got=%b exp=1", ir64); end
    @(negedge clk);
    checks++; if ({ov64, r64, c64, v64, z64} !== {1'b1, 64'd0, 1'b1, 1'b0, 1'b1}) begin errors++; $display("FAIL add_wrap got ov=%b r=%h cvz=%b%b%b exp ov=1 r=0 cvz=101", ov64, r64, c64, v64, z64); end
    a64 = 64'h8000_0000_0000_0000; b64 = 64'd1; op64 = 4'b1000;
    @(negedge clk);
    checks++; if ({ov64, r64, c64, v64, z64} !== {1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_ovf got ov=%b r=%h cvz=%b%b%b exp r=7fffffffffffffff cvz=110", ov64, r64, c64, v64, z64); end
    a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'd1; op64 = 4'b0000;
    @(negedge clk);
    checks++; if ({r64, c64, v64, z64} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL add_ovf got r=%h cvz=%b%b%b exp r=8000000000000000 cvz=010", r64, c64, v64, z64); end
    iv64 = 1'b0;
    @(negedge clk);
    checks++; if (ov64 !== 1'b0) begin errors++; $display("FAIL valid_clear got=%b exp=0", ov64); end
  endtask

  task automatic test_undefined();
    @(negedge clk);
    a64 = 64'h1234_5678_9ABC_DEF0; b64 = 64'h0F0F_0F0F_0F0F_0F0F; op64 = 4'b1111; iv64 = 1'b1; or64 = 1'b1;
    a8 = 8'h5A; b8 = 8'hC3; op8 = 4'b1111; iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    checks++; if ({ov64, r64, c64, v64, z64} !== {1'b1, 64'd0, 3'b001}) begin errors++; $display("FAIL undef64_f got ov=%b r=%h cvz=%b%b%b exp ov=1 r=0 cvz=001", ov64, r64, c64, v64, z64); end
    checks++; if ({ov8, r8, c8, v8, z8} !== {1'b1, 8'd0, 3'b001}) begin errors++; $display("FAIL undef8_f got ov=%b r=%h cvz=%b%b%b exp ov=1 r=0 cvz=001", ov8, r8, c8, v8, z8); end
`ifndef ALU_PIPE_MUL_EN
    a64 = 64'd6; b64 = 64'd7; op64 = 4'b1001; a8 = 8'd6; b8 = 8'd7; op8 = 4'b1001;
    @(negedge clk);
    checks++; if ({ov64, r64, c64, v64, z64} !== {1'b1, 64'd0, 3'b001}) begin errors++; $display("FAIL undef64_9 got ov=%b r=%h cvz=%b%b%b exp ov=1 r=0 cvz=001", ov64, r64, c64, v64, z64); end
    checks++; if ({ov8, r8, c8, v8, z8, busy8} !== {1'b1, 8'd0, 3'b001, 1'b0}) begin errors++; $display("FAIL undef8_9 got ov=%b r=%h cvz=%b%b%b busy=%b exp ov=1 r=0 cvz=001 busy=0", ov8, r8, c8, v8, z8, busy8); end
`endif
    iv64 = 1'b0; iv8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] x, y;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    @(negedge clk);
    a64 = x; b64 = y; op64 = 4'b0111; iv64 = 1'b1; or64 = 1'b0;
    #1;
    checks++; if (ir64 !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got=%b exp=1", ir64); end
    @(negedge clk);
    op64 = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if ({ov64, r64, ir64} !== {1'b1, x & y, 1'b0}) begin errors++; $display("FAIL b2b_hold%0d got ov=%b r=%h ir=%b exp ov=1 r=%h ir=0", i, ov64, r64, ir64, x & y); end
    end
    @(negedge clk);
    or64 = 1'b1;
    #1;
    checks++; if ({ir64, r64} !== {1'b1, x & y}) begin errors++; $display("FAIL b2b_release got ir=%b r=%h exp ir=1 r=%h", ir64, r64, x & y); end
    @(negedge clk);
    checks++; if ({ov64, r64, c64, v64} !== {1'b1, x | y, 2'b00}) begin errors++; $display("FAIL b2b_or got ov=%b r=%h cv=%b%b exp r=%h", ov64, r64, c64, v64, x | y); end
    op64 = 4'b0100;
    @(negedge clk);
    checks++; if ({ov64, r64} !== {1'b1, x ^ y}) begin errors++; $display("FAIL b2b_xor got ov=%b r=%h exp r=%h", ov64, r64, x ^ y); end
    iv64 = 1'b0;
    @(negedge clk);
    checks++; if (ov64 !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", ov64); end
  endtask

  task automatic test_random_64(input int n);
    exp_t q[$];
    exp_t e;
    logic [3:0] ops [12];
    int sent = 0;
    int cyc = 0;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13, 4'd15, 4'd9};
    while ((sent < n || q.size() != 0) && cyc < n * 80 + 200) begin
      @(negedge clk);
      cyc++;
      iv64 = (sent < n) && ($urandom_range(0, 3) != 0);
      op64 = ops[$urandom_range(0, 11)];
      a64 = pick64();
      b64 = pick64();
      or64 = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (ir64 !== (!busy64 && (!ov64 || or64))) begin errors++; $display("FAIL rnd64_ready got=%b busy=%b ov=%b or=%b", ir64, busy64, ov64, or64); end
      if (ov64 && or64) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd64_spurious got result %h exp none", r64); end
        else begin
          e = q.pop_front();
          if ({r64, c64, v64, z64} !== {e.r, e.c, e.v, e.z}) begin errors++; $display("FAIL rnd64 got r=%h cvz=%b%b%b exp r=%h cvz=%b%b%b", r64, c64, v64, z64, e.r, e.c, e.v, e.z); end
        end
      end
      if (iv64 && ir64) begin
        ref_op(64, op64, a64, b64, e.r, e.c, e.v, e.z);
        q.push_back(e);
        sent++;
      end
    end
    iv64 = 1'b0;
    checks++; if (q.size() != 0 || sent != n) begin errors++; $display("FAIL rnd64_timeout got sent=%0d pending=%0d exp sent=%0d pending=0", sent, q.size(), n); end
  endtask

  task automatic test_random_8(input int n);
    exp_t q[$];
    exp_t e;
    logic [3:0] ops [12];
    int sent = 0;
    int cyc = 0;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13, 4'd15, 4'd9};
    while ((sent < n || q.size() != 0) && cyc < n * 20 + 200) begin
      @(negedge clk);
      cyc++;
      iv8 = (sent < n) && ($urandom_range(0, 3) != 0);
      op8 = ops[$urandom_range(0, 11)];
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      or8 = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (ir8 !== (!busy8 && (!ov8 || or8))) begin errors++; $display("FAIL rnd8_ready got=%b busy=%b ov=%b or=%b", ir8, busy8, ov8, or8); end
      if (ov8 && or8) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd8_spurious got result %h exp none", r8); end
        else begin
          e = q.pop_front();
          if ({r8, c8, v8, z8} !== {e.r[7:0], e.c, e.v, e.z}) begin errors++; $display("FAIL rnd8 got r=%h cvz=%b%b%b exp r=%h cvz=%b%b%b", r8, c8, v8, z8, e.r[7:0], e.c, e.v, e.z); end
        end
      end
      if (iv8 && ir8) begin
        ref_op(8, op8, {56'd0, a8}, {56'd0, b8}, e.r, e.c, e.v, e.z);
        q.push_back(e);
        sent++;
      end
    end
    iv8 = 1'b0;
    checks++; if (q.size() != 0 || sent != n) begin errors++; $display("FAIL rnd8_timeout got sent=%0d pending=%0d exp sent=%0d pending=0", sent, q.size(), n); end
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul();
    int busy_cnt = 0;
    int ov_at = 0;
    int k = 1;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; op8 = 4'b1001; iv8 = 1'b1; or8 = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL mul_accept got=%b exp=1", ir8); end
    @(negedge clk);
    op8 = 4'b0000;
    while (ov_at == 0 && k < 40) begin
      if (busy8) busy_cnt++;
      if (ov8) ov_at = k;
      else begin
        @(negedge clk);
        k++;
        a8 = 8'($urandom); b8 = 8'($urandom);
        iv8 = (k < 6);
      end
    end
    iv8 = 1'b0;
    checks++; if (busy_cnt != 8 || ov_at != 9) begin errors++; $display("FAIL mul_latency got busy=%0d valid_at=%0d exp busy=8 valid_at=9", busy_cnt, ov_at); end
    checks++; if ({r8, c8, v8, z8, busy8} !== {8'h00, 3'b011, 1'b0}) begin errors++; $display("FAIL mul_10x20 got r=%h cvz=%b%b%b busy=%b exp r=00 cvz=011 busy=0", r8, c8, v8, z8, busy8); end
    @(negedge clk);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL mul_ignored_in got ov=%b exp=0", ov8); end
    a8 = 8'h0F; b8 = 8'h11; op8 = 4'b1001; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    k = 0;
    while (!ov8 && k < 40) begin @(negedge clk); k++; end
    checks++; if ({ov8, r8, c8, v8, z8} !== {1'b1, 8'hFF, 3'b000}) begin errors++; $display("FAIL mul_0fx11 got ov=%b r=%h cvz=%b%b%b exp ov=1 r=ff cvz=000", ov8, r8, c8, v8, z8); end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    int extra = 0;
    @(negedge clk);
`ifdef ALU_PIPE_MUL_EN
    a8 = 8'd7; b8 = 8'd9; op8 = 4'b1001; iv8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
`else
    a8 = 8'd1; b8 = 8'd1; op8 = 4'b0000; iv8 = 1'b1; or8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk);
`endif
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({busy8, ov8, r8} !== {1'b0, 1'b0, 8'd0}) begin errors++; $display("FAIL rst_mid got busy=%b ov=%b r=%h exp busy=0 ov=0 r=00", busy8, ov8, r8); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a8 = 8'd2; b8 = 8'd3; op8 = 4'b0000; iv8 = 1'b1; or8 = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ir8); end
    @(negedge clk);
    iv8 = 1'b0;
    checks++; if ({ov8, r8} !== {1'b1, 8'd5}) begin errors++; $display("FAIL rst_add got ov=%b r=%h exp ov=1 r=05", ov8, r8); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov8) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rst_ghost got %0d valid cycles exp 0", extra); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_sub_corners();
    test_undefined();
    test_back_to_back();
`ifdef ALU_PIPE_MUL_EN
    test_mul();
`endif
    test_reset_mid();
    test_random_64(150);
    test_random_8(120);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
